mem_boot_loader: RTL and testbench

- Upstream companion of singleMips: holds the CPU in reset, zero-fills its data memory, then streams a byte-serial image into memory words.
- Releases the CPU reset once loading completes.
- Replaces bench-side direct memory initialisation with a synthesizable load path; the memory write port is shared with the CPU via an external mux selected by busy.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/word_assembler.sv | 57 +++++
 rtl/mem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_mem_boot_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Definitions shared between the boot loader and the singleMips
//               data memory: loader state encoding, word geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Memory word width, shared with the singleMips data memory
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs a big-endian byte stream into memory words. The first
//               byte of a word lands in bits 31:24. A byte flagged as last
//               closes the word early, and the unfilled low bytes read zero.
// Ports       : clk, rst (sync, active-low), clear (sync flush of a partial
//               word), accept (byte handshake), in_byte, in_last,
//               word_done (pulse in the accepting cycle), word (finished word,
//               valid while word_done is high)
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              word_done,
    output logic [DATA_W-1:0] word
);

    localparam logic [1:0] C_LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [DATA_W-1:0] r_acc;  // bytes received so far, already in final lanes
    logic [1:0]        r_idx;  // lane of the next byte, 0 = bits 31:24
    logic [4:0]        w_shift;

    // Lanes below the current byte are still zero in r_acc, which provides
    // the zero padding when in_last closes the word early.
    assign w_shift   = {r_idx, 3'b000};
    assign word      = r_acc | ({in_byte, (DATA_W - 8)'(0)} >> w_shift);
    assign word_done = accept & (in_last | (r_idx == C_LAST_IDX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (accept) begin
            if (word_done) begin
                r_acc <= '0;
                r_idx <= '0;
            end else begin
                r_acc <= word;
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule : word_assembler
`default_nettype wire

// File: rtl/mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_boot_loader
// Description : Holds singleMips in reset, zero-fills its data memory, then
//               writes a byte-serial big-endian image into memory words and
//               releases the CPU reset. busy selects the loader onto the
//               shared memory write port.
// Ports       : clk, rst (sync, active-low), start, in_valid/in_byte/in_last/
//               in_ready (byte stream), mem_we/mem_addr/mem_wdata (memory
//               write port), busy, done, words_loaded, cpu_rst (active-high),
//               cksum (only with MEM_BOOT_LOADER_CKSUM_EN defined)
// Options     : MEM_BOOT_LOADER_CKSUM_EN adds a modulo-2^32 sum of the image
//               words written during LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_rst
`ifdef MEM_BOOT_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);

    localparam int              DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] C_LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_t     r_state;

    logic              w_accept;
    logic              w_asm_clear;
    logic              w_word_done;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W:0]   w_wr_idx;
    logic              w_final;

    assign w_accept    = in_valid & in_ready;
    // Every load passes through CLEAR, so flushing there discards any
    // partial word left over from an earlier image.
    assign w_asm_clear = (r_state == ST_CLEAR);

    // Index of the word being completed now. While a previous write strobe
    // is still on the port, its address has not been advanced yet.
    assign w_wr_idx = words_loaded + {{ADDR_W{1'b0}}, mem_we};
    assign w_final  = in_last | (w_wr_idx == C_LAST_WORD);

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_asm_clear),
        .accept    (w_accept),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .word_done (w_word_done),
        .word      (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            cpu_rst      <= 1'b1;
`ifdef MEM_BOOT_LOADER_CKSUM_EN
            cksum        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_CLEAR;
                        mem_we       <= 1'b1;
                        mem_addr     <= '0;
                        mem_wdata    <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        cpu_rst      <= 1'b1;
`ifdef MEM_BOOT_LOADER_CKSUM_EN
                        cksum        <= '0;
`endif
                    end
                end

                ST_CLEAR: begin
                    if (mem_addr == C_LAST_ADDR) begin
                        r_state  <= ST_LOAD;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end

                ST_LOAD: begin
                    mem_we <= 1'b0;
                    // Retire the write strobe on the port. in_ready already
                    // low here means that write was the final word.
                    if (mem_we) begin
                        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                        if (in_ready) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end else begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end
                    end
                    // A single-byte word closed by in_last can complete while
                    // the previous strobe is still retiring; the address
                    // advances on the same edge, so both land correctly.
                    if (w_word_done) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= w_word;
`ifdef MEM_BOOT_LOADER_CKSUM_EN
                        cksum     <= cksum + w_word;
`else
                        // No running sum without the checksum option.
`endif
                        if (w_final) begin
                            in_ready <= 1'b0;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : mem_boot_loader
`default_nettype wire

// File: tb/tb_mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_boot_loader
// Description : Self-checking bench for mem_boot_loader. Stimulus pushes the
//               memory writes it expects into a scoreboard queue; a monitor
//               pops and compares on every write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_boot_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_loaded;
    logic              cpu_rst;
`ifdef MEM_BOOT_LOADER_CKSUM_EN
    logic [31:0]       cksum;
`endif

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t q_exp[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    mem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded),
        .cpu_rst      (cpu_rst)
`ifdef MEM_BOOT_LOADER_CKSUM_EN
        ,
        .cksum        (cksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q_exp.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", mem_wdata, e.d);
            end
        end
    end

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.a = ADDR_W'(a);
        e.d = d;
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, optionally pulse it again mid-CLEAR, wait for LOAD
    task automatic do_start(input bit extra_pulse);
        bit got;
        for (int i = 0; i < DEPTH; i++) push_wr(i, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        if (extra_pulse) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1;
            tick();
            start = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("clear_to_load", 32'(got), 32'd1);
        chk("load_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("clear_all_seen", 32'(q_exp.size()), 32'd0);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit got;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_check(input int nwords, input logic [31:0] exp_sum);
        @(negedge clk);
        chk("fin_in_ready", 32'(in_ready), 32'd0);
        chk("fin_we", 32'(mem_we), 32'd1);
        chk("fin_cpu_rst_hold", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("cpu_rst_release", 32'(cpu_rst), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(mem_we), 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(nwords));
`ifdef MEM_BOOT_LOADER_CKSUM_EN
        chk("cksum", cksum, exp_sum);
`else
        if (exp_sum === 32'hx) $display("unused");
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v[12];
        logic [31:0] sum;
        logic [31:0] w;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        tick();

        // 12 bytes, in_last on the 12th
        do_start(1'b0);
        v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h11, 8'h11};
        push_wr(0, 32'h0000_0000);
        push_wr(1, 32'h0000_0000);
        push_wr(2, 32'h0000_1111);
        for (int i = 0; i < 12; i++) send_byte(v[i], i == 11);
        finish_check(3, 32'h0000_1111);

        // DONE + start: 6 bytes, last word zero padded
        do_start(1'b0);
        push_wr(0, 32'hAABB_CCDD);
        push_wr(1, 32'h1234_0000);
        v = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h12, 8'h34, 8'h0, 8'h0,
              8'h0, 8'h0, 8'h0, 8'h0};
        for (int i = 0; i < 6; i++) send_byte(v[i], i == 5);
        finish_check(2, 32'hBCEF_CCDD);

        // in_last on the first byte of a word
        do_start(1'b0);
        push_wr(0, 32'h7F00_0000);
        send_byte(8'h7F, 1'b1);
        finish_check(1, 32'h7F00_0000);

        // Full memory: 256 bytes with random gaps, no in_last
        do_start(1'b0);
        sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            push_wr(k, w);
            sum = sum + w;
        end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'(i), 1'b0);
        end
        finish_check(64, sum);
        chk("full_last_addr", 32'(mem_addr), 32'd63);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            chk("byte257_not_taken", 32'(in_ready), 32'd0);
        end
        tick();
        in_valid = 1'b0;

        // start during CLEAR is ignored; reset mid-LOAD aborts
        do_start(1'b1);
        push_wr(0, 32'h0102_0304);
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0, 8'h0, 8'h0,
              8'h0, 8'h0, 8'h0, 8'h0};
        for (int i = 0; i < 5; i++) send_byte(v[i], 1'b0);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd0);
        chk("abort_sb_empty", 32'(q_exp.size()), 32'd0);
        tick();

        // Re-run after abort: CLEAR from address 0, stale partial discarded
        do_start(1'b0);
        push_wr(0, 32'hDEAD_BEEF);
        v = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0, 8'h0, 8'h0, 8'h0,
              8'h0, 8'h0, 8'h0, 8'h0};
        for (int i = 0; i < 4; i++) send_byte(v[i], i == 3);
        finish_check(1, 32'hDEAD_BEEF);

        repeat (3) tick();
        chk("final_sb_empty", 32'(q_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_boot_loader
`default_nettype wire
